card_dealer_rng: RTL

Parametrised random card source for the blackjack datapath. It deals from a deck without replacement, so no card repeats until a shuffle. A free-running Galois LFSR seeds each draw. A used-card bitmap with linear probing guarantees a unique card index. The dealer FSM issues draws through a request/valid handshake; the block reports rank, suit, cards remaining and deck-empty status.

---
 rtl/card_pkg.sv | 28 ++
 rtl/lfsr_galois.sv | 33 +++
 rtl/card_dealer_rng.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/card_pkg.sv
// Shared types, defaults and index folding for the card dealer.
//   dealer_state_t : dealer FSM states
//   DEFAULT_*      : default deck and LFSR configuration
//   fold_index     : maps a random word onto 0..deck_size-1
package card_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } dealer_state_t;

    localparam int unsigned DEFAULT_DECK_SIZE  = 52;
    localparam int unsigned DEFAULT_RANKS      = 13;
    localparam int unsigned DEFAULT_LFSR_WIDTH = 16;
    localparam logic [15:0] DEFAULT_LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED       = 16'hACE1;

    // Low idx_w bits, minus one deck if they overshoot. A single subtraction
    // suffices because the deck covers more than half the index space.
    function automatic int unsigned fold_index(input int unsigned x,
                                               input int unsigned idx_w,
                                               input int unsigned deck_size);
        int unsigned low;
        low = x & ((32'd1 << idx_w) - 32'd1);
        return (low < deck_size) ? low : (low - deck_size);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR, shifting right with feedback mask TAPS.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, loads SEED
//   o_state : current LFSR register (never zero for nonzero SEED)
module lfsr_galois
    import card_pkg::*;
#(
    parameter int unsigned         WIDTH = DEFAULT_LFSR_WIDTH,
    parameter logic [WIDTH-1:0]    TAPS  = DEFAULT_LFSR_TAPS,
    parameter logic [WIDTH-1:0]    SEED  = DEFAULT_SEED
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // One Galois step per cycle.
    assign state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/card_dealer_rng.sv
// Deals unique cards from a deck without replacement until shuffled.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_request      : draw request, honoured only while idle
//   i_shuffle      : return every card to the deck, aborting any draw
//   o_valid        : one-cycle pulse with a newly dealt card
//   o_card/o_rank/o_suit : dealt card, held until the next deal
//   o_remaining, o_empty : undealt card count and deck-empty flag
//   o_busy         : draw in progress
//   o_err          : one-cycle pulse, request against an empty deck
module card_dealer_rng
    import card_pkg::*;
#(
    parameter int unsigned              DECK_SIZE  = DEFAULT_DECK_SIZE,
    parameter int unsigned              RANKS      = DEFAULT_RANKS,
    parameter int unsigned              LFSR_WIDTH = DEFAULT_LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0]    LFSR_TAPS  = DEFAULT_LFSR_TAPS,
    parameter logic [LFSR_WIDTH-1:0]    SEED       = DEFAULT_SEED,
    localparam int unsigned IDX_W  = $clog2(DECK_SIZE),
    localparam int unsigned RANK_W = ($clog2(RANKS) > 0) ? $clog2(RANKS) : 1,
    localparam int unsigned SUIT_W = ($clog2(DECK_SIZE / RANKS) > 0) ? $clog2(DECK_SIZE / RANKS) : 1,
    localparam int unsigned REM_W  = IDX_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_request,
    input  logic              i_shuffle,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_card,
    output logic [RANK_W-1:0] o_rank,
    output logic [SUIT_W-1:0] o_suit,
    output logic [REM_W-1:0]  o_remaining,
    output logic              o_empty,
    output logic              o_busy,
    output logic              o_err
);

    logic [LFSR_WIDTH-1:0] lfsr;
    logic [IDX_W-1:0]      fold_c;

    dealer_state_t         state_q, state_d;
    logic [IDX_W-1:0]      cand_q, cand_d;
    logic [DECK_SIZE-1:0]  used_q, used_d;
    logic [IDX_W-1:0]      card_q, card_d;
    logic [RANK_W-1:0]     rank_q, rank_d;
    logic [SUIT_W-1:0]     suit_q, suit_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic                  empty_q, empty_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    lfsr_galois #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_state (lfsr)
    );

    // Starting candidate for a new draw.
    assign fold_c = IDX_W'(fold_index(32'(lfsr), IDX_W, DECK_SIZE));

    // Dealer FSM: pick a random start, then probe linearly for a free card.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        used_d  = used_q;
        card_d  = card_q;
        rank_d  = rank_q;
        suit_d  = suit_q;
        rem_d   = rem_q;
        empty_d = empty_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_request) begin
                    if (empty_q) begin
                        err_d = 1'b1;
                    end else begin
                        cand_d  = fold_c;
                        state_d = PROBE;
                    end
                end
            end
            PROBE: begin
                if (!used_q[cand_q]) begin
                    used_d[cand_q] = 1'b1;
                    card_d  = cand_q;
                    rank_d  = RANK_W'(32'(cand_q) % RANKS);
                    suit_d  = SUIT_W'(32'(cand_q) / RANKS);
                    valid_d = 1'b1;
                    rem_d   = rem_q - REM_W'(1);
                    empty_d = (rem_q == REM_W'(1));
                    state_d = IDLE;
                end else begin
                    cand_d = (cand_q == IDX_W'(DECK_SIZE - 1)) ? '0 : cand_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Shuffle overrides everything except the held card outputs.
        if (i_shuffle) begin
            used_d  = '0;
            rem_d   = REM_W'(DECK_SIZE);
            empty_d = 1'b0;
            state_d = IDLE;
            card_d  = card_q;
            rank_d  = rank_q;
            suit_d  = suit_q;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end

        busy_d = (state_d == PROBE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cand_q  <= '0;
            used_q  <= '0;
            card_q  <= '0;
            rank_q  <= '0;
            suit_q  <= '0;
            rem_q   <= REM_W'(DECK_SIZE);
            empty_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            used_q  <= used_d;
            card_q  <= card_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
            rem_q   <= rem_d;
            empty_q <= empty_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_card      = card_q;
    assign o_rank      = rank_q;
    assign o_suit      = suit_q;
    assign o_remaining = rem_q;
    assign o_empty     = empty_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

endmodule
